// File: rtl/clock_step_pkg.sv
// Shared state encoding and filter depth for the processor clock-step sequencer.
package clock_step_pkg;

  typedef enum logic [1:0] {
    ST_STEP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam int FILT_DEPTH = 3;

endpackage

// File: rtl/btn_filter.sv
// Button debounce: a press is FILT_DEPTH consecutive high samples, reported as one
// registered single-cycle event on the rising edge of the filtered level.
module btn_filter
  import clock_step_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  input  logic raw,
  output logic press
);

  logic [FILT_DEPTH-1:0] sh;
  logic                  filt;
  logic                  filt_d;

  assign filt = &sh;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sh     <= '0;
      filt_d <= 1'b0;
      press  <= 1'b0;
    end else begin
      sh     <= {sh[FILT_DEPTH-2:0], raw};
      filt_d <= filt;
      press  <= filt & ~filt_d;
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Decides when the processor advances: single-step, free-run and IN-instruction
// handshake, all reduced to a registered one-cycle cpu_en strobe.
module clock_step_ctrl
  import clock_step_pkg::*;
#(
  parameter int SW_W    = 16,
  parameter int DIV_W   = 24,
  parameter int RUN_DIV = 5_000_000
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            btn_step,
  input  logic            btn_confirm,
  input  logic            run_mode,
  input  logic            halt,
  input  logic            in_req,
  input  logic [SW_W-1:0] sw,
  output logic            cpu_en,
  output logic [SW_W-1:0] in_data,
  output logic            in_ack,
  output logic [1:0]      state_dbg
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div;
  logic              tick, tick_nxt;
  logic              run_m, run_s;
  logic              step_press, confirm_press;
  logic              en_nxt, ack_nxt, latch, div_clr, div_adv;

  btn_filter u_step_filt (
    .clk     (clk),
    .n_reset (n_reset),
    .raw     (btn_step),
    .press   (step_press)
  );

  btn_filter u_confirm_filt (
    .clk     (clk),
    .n_reset (n_reset),
    .raw     (btn_confirm),
    .press   (confirm_press)
  );

  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    latch     = 1'b0;
    div_clr   = 1'b0;
    div_adv   = 1'b0;
    tick_nxt  = 1'b0;
    case (state)
      ST_STEP: begin
        if (halt)            state_nxt = ST_HALTED;
        else if (in_req)     state_nxt = ST_WAIT_IN;
        else if (run_s) begin
          state_nxt = ST_RUN;
          div_clr   = 1'b1;
        end else if (step_press) en_nxt = 1'b1;
      end
      ST_RUN: begin
        if (halt)            state_nxt = ST_HALTED;
        else if (in_req)     state_nxt = ST_WAIT_IN;
        else if (!run_s)     state_nxt = ST_STEP;
        else begin
          // tick marks the wrap; the strobe follows it by one cycle
          div_adv  = 1'b1;
          tick_nxt = (div == DIV_LAST);
          en_nxt   = tick;
        end
      end
      ST_WAIT_IN: begin
        if (halt) state_nxt = ST_HALTED;
        else if (confirm_press) begin
          latch   = 1'b1;
          ack_nxt = 1'b1;
          en_nxt  = 1'b1;
          if (run_s) begin
            state_nxt = ST_RUN;
            div_clr   = 1'b1;
          end else begin
            state_nxt = ST_STEP;
          end
        end
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= ST_STEP;
      div     <= '0;
      tick    <= 1'b0;
      run_m   <= 1'b0;
      run_s   <= 1'b0;
      cpu_en  <= 1'b0;
      in_ack  <= 1'b0;
      in_data <= '0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      run_m  <= run_mode;
      run_s  <= run_m;
      cpu_en <= en_nxt;
      in_ack <= ack_nxt;
      if (latch) in_data <= sw;
      if (div_clr)      div <= '0;
      else if (div_adv) div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Randomised and directed bench for clock_step_ctrl against a behavioural model
// built from run lengths, input history and elapsed time in RUN.
module tb_clock_step_ctrl;

  localparam int SW_W    = 16;
  localparam int DIV_W   = 24;
  localparam int RUN_DIV = 4;

  logic            clk = 1'b0;
  logic            n_reset, btn_step, btn_confirm, run_mode, halt, in_req;
  logic [SW_W-1:0] sw;
  logic            cpu_en, in_ack;
  logic [SW_W-1:0] in_data;
  logic [1:0]      state_dbg;

  clock_step_ctrl #(.SW_W(SW_W), .DIV_W(DIV_W), .RUN_DIV(RUN_DIV)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .btn_step    (btn_step),
    .btn_confirm (btn_confirm),
    .run_mode    (run_mode),
    .halt        (halt),
    .in_req      (in_req),
    .sw          (sw),
    .cpu_en      (cpu_en),
    .in_data     (in_data),
    .in_ack      (in_ack),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: consecutive-high run lengths (one and two edges back), run_mode history,
  // mode, cycles spent in RUN, and the registered outputs
  int              rs1, rs2, rc1, rc2;
  bit              rm1, rm2;
  int              m_state;
  int              age;
  bit              m_en, m_ack;
  logic [SW_W-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ps, pc, rs;
    if (!n_reset) begin
      rs1 = 0; rs2 = 0; rc1 = 0; rc2 = 0; rm1 = 0; rm2 = 0;
      m_state = 0; age = 0; m_en = 0; m_ack = 0; m_data = '0;
      return;
    end
    ps = (rs2 == 3);
    pc = (rc2 == 3);
    rs = rm2;
    m_en  = 0;
    m_ack = 0;
    case (m_state)
      0: begin
        if (halt) m_state = 3;
        else if (in_req) m_state = 2;
        else if (rs) begin m_state = 1; age = 0; end
        else if (ps) m_en = 1;
      end
      1: begin
        if (halt) m_state = 3;
        else if (in_req) m_state = 2;
        else if (!rs) m_state = 0;
        else begin
          age++;
          if (age > RUN_DIV && (age - 1) % RUN_DIV == 0) m_en = 1;
        end
      end
      2: begin
        if (halt) m_state = 3;
        else if (pc) begin
          m_ack = 1; m_en = 1; m_data = sw;
          if (rs) begin m_state = 1; age = 0; end
          else m_state = 0;
        end
      end
      default: m_state = 3;
    endcase
    rs2 = rs1; rs1 = btn_step    ? ((rs1 < 7) ? rs1 + 1 : 7) : 0;
    rc2 = rc1; rc1 = btn_confirm ? ((rc1 < 7) ? rc1 + 1 : 7) : 0;
    rm2 = rm1; rm1 = run_mode;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
    check("in_ack", {31'd0, in_ack}, {31'd0, m_ack});
    check("in_data", {16'd0, in_data}, {16'd0, m_data});
    check("state_dbg", {30'd0, state_dbg}, m_state);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    cyc();
    n_reset = 1'b1;
  endtask

  initial begin
    int cnt, pos, seen, bs, bc;
    logic [SW_W-1:0] v;
    n_reset = 1'b0; btn_step = 0; btn_confirm = 0; run_mode = 0;
    halt = 0; in_req = 0; sw = '0;
    cyc();
    cyc();
    check("reset_en", {31'd0, cpu_en}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    check("reset_data", {16'd0, in_data}, 32'd0);
    n_reset = 1'b1;
    idle(4);

    // single step: button held 10 cycles
    cnt = 0; pos = -1;
    for (int i = 0; i < 14; i++) begin
      btn_step = (i < 10);
      cyc();
      if (cpu_en) begin cnt++; pos = i; end
    end
    check("step_count", cnt, 1);
    check("step_latency", pos, 4);

    // bounce rejection then a clean press
    begin
      bit pat [7] = '{1, 1, 0, 1, 0, 1, 1};
      cnt = 0;
      for (int i = 0; i < 13; i++) begin
        btn_step = (i < 7) ? pat[i] : 1'b0;
        cyc();
        if (cpu_en) cnt++;
      end
      check("bounce_none", cnt, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        btn_step = (i < 3);
        cyc();
        if (cpu_en) cnt++;
      end
      check("bounce_clean", cnt, 1);
    end

    // free run cadence, step presses ignored
    run_mode = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      if (state_dbg == 2'd1) seen = 1;
    end
    check("run_entered", seen, 1);
    for (int j = 1; j <= 30; j++) begin
      btn_step = ((j / 5) % 2 == 1);
      cyc();
      check("run_cadence", {31'd0, cpu_en}, (j >= 5 && (j - 5) % RUN_DIV == 0) ? 32'd1 : 32'd0);
    end
    btn_step = 0;

    // IN handshake from RUN
    sw = 16'hA5C3; in_req = 1;
    idle(4);
    check("wait_state", {30'd0, state_dbg}, 32'd2);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      btn_confirm = (i < 5);
      cyc();
      if (in_ack) begin
        seen = 1;
        check("ack_en", {31'd0, cpu_en}, 32'd1);
        check("ack_data", {16'd0, in_data}, 32'h0000A5C3);
        in_req = 0;
      end else begin
        check("wait_hold", {30'd0, state_dbg}, 32'd2);
      end
    end
    check("ack_seen", seen, 1);
    btn_confirm = 0; in_req = 0;
    cyc();
    check("after_ack_state", {30'd0, state_dbg}, 32'd1);

    // reset in RUN
    idle(6);
    do_reset();
    check("rst_run_state", {30'd0, state_dbg}, 32'd0);
    check("rst_run_data", {16'd0, in_data}, 32'd0);

    // halt coincident with confirm press in WAIT_IN
    run_mode = 0; sw = 16'h1234;
    idle(4);
    in_req = 1;
    idle(2);
    check("halt_pre_wait", {30'd0, state_dbg}, 32'd2);
    for (int i = 0; i < 6; i++) begin
      btn_confirm = (i < 5);
      if (i == 4) halt = 1;
      cyc();
    end
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      btn_step = $urandom_range(0, 1);
      btn_confirm = $urandom_range(0, 1);
      run_mode = $urandom_range(0, 1);
      cyc();
      if (cpu_en || in_ack) cnt++;
    end
    check("halt_quiet", cnt, 0);
    check("halt_state", {30'd0, state_dbg}, 32'd3);
    check("halt_data", {16'd0, in_data}, 32'd0);

    // reset mid-WAIT_IN
    halt = 0; btn_step = 0; btn_confirm = 0; run_mode = 0;
    do_reset();
    idle(4);
    check("rewait_state", {30'd0, state_dbg}, 32'd2);
    do_reset();
    check("rst_wait_state", {30'd0, state_dbg}, 32'd0);
    check("rst_wait_ack", {31'd0, in_ack}, 32'd0);
    in_req = 0;
    idle(4);

    // random operation
    bs = 0; bc = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bs = !bs;
      if ($urandom_range(0, 3) == 0) bc = !bc;
      btn_step = bs; btn_confirm = bc;
      if ($urandom_range(0, 59) == 0) run_mode = !run_mode;
      if (!in_req && $urandom_range(0, 19) == 0) begin
        in_req = 1;
        v = SW_W'($urandom);
        sw = v;
      end
      if (!halt && $urandom_range(0, 799) == 0) halt = 1;
      if (halt && $urandom_range(0, 29) == 0) begin
        halt = 0; in_req = 0;
        do_reset();
      end else if ($urandom_range(0, 999) == 0) begin
        in_req = 0;
        do_reset();
      end else begin
        cyc();
        if (m_ack) in_req = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
